// File: rtl/grid_cell_arbiter.sv
// Round-robin arbiter giving NREQ placement engines atomic read / claim / write / release
// access to a single-port grid RAM with a one-cycle registered read.
module grid_cell_arbiter #(
  parameter int                 NREQ   = 4,
  parameter int                 GRID_N = 6,
  parameter logic signed [31:0] EMPTY  = -32'sd1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [32*NREQ-1:0]     addr,
  input  logic [32*NREQ-1:0]     wdata,
  output logic [NREQ-1:0]        ack,
  output logic                   ok,
  output logic [31:0]            rdata,
  output logic                   busy,
  output logic [31:0]            fail_cnt,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_din,
  input  logic [31:0]            mem_dout
);

  localparam int PW    = $clog2(NREQ);
  localparam int CELLS = GRID_N * GRID_N;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_WR, S_RESP} state_e;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_CLAIM = 2'b01,
                            OP_WRITE = 2'b10, OP_RELEASE = 2'b11} op_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d, gnt_q, gnt_d;
  op_e                op_q, op_d;
  logic signed [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]        cell_q, cell_d;
  logic               res_ok_q, res_ok_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               ok_q, ok_d, busy_q, busy_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [31:0]        rdata_q, rdata_d, fail_cnt_q, fail_cnt_d;
  logic [31:0]        mem_addr_q, mem_addr_d, mem_din_q, mem_din_d;

  logic [NREQ-1:0]    req_eff;
  logic               found;
  logic [PW-1:0]      pick;
  op_e                pick_op;
  logic signed [31:0] pick_addr, pick_wdata;
  logic               pick_legal;

  // Scans offsets from the highest down so the lowest offset from ptr wins.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0] ptr,
                                            output logic any);
    int idx;
    any     = 1'b0;
    rr_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (r[idx]) begin
        any     = 1'b1;
        rr_pick = PW'(idx);
      end
    end
  endfunction

  // A requester still shows req in its own ack cycle; masking it avoids a stale regrant.
  always_comb begin
    req_eff    = req & ~ack_q;
    pick       = rr_pick(req_eff, rr_ptr_q, found);
    pick_op    = op_e'(op[2*int'(pick) +: 2]);
    pick_addr  = addr[32*int'(pick) +: 32];
    pick_wdata = wdata[32*int'(pick) +: 32];
    pick_legal = (pick_addr >= 0) && (pick_addr < CELLS);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (found) state_d = pick_legal ? S_RD : S_RESP;
      S_RD:   state_d = S_CHK;
      S_CHK: begin
        unique case (op_q)
          OP_READ:    state_d = S_RESP;
          OP_CLAIM:   state_d = (mem_dout == EMPTY)   ? S_WR : S_RESP;
          OP_WRITE:   state_d = S_WR;
          OP_RELEASE: state_d = (mem_dout == wdata_q) ? S_WR : S_RESP;
          default:    state_d = S_RESP;
        endcase
      end
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    gnt_d      = gnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cell_d     = cell_q;
    res_ok_d   = res_ok_q;
    rr_ptr_d   = rr_ptr_q;
    ack_d      = '0;
    ok_d       = 1'b0;
    rdata_d    = '0;
    busy_d     = (state_d != S_IDLE);
    fail_cnt_d = fail_cnt_q;
    mem_re_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    unique case (state_q)
      S_IDLE: if (found) begin
        gnt_d   = pick;
        op_d    = pick_op;
        addr_d  = pick_addr;
        wdata_d = pick_wdata;
        if (pick_legal) begin
          mem_re_d   = 1'b1;
          mem_addr_d = pick_addr;
        end else begin
          res_ok_d = 1'b0;
          cell_d   = EMPTY;
        end
      end
      S_CHK: begin
        cell_d   = mem_dout;
        res_ok_d = (state_d == S_WR) || (op_q == OP_READ);
        if (state_d == S_WR) begin
          mem_we_d  = 1'b1;
          mem_din_d = (op_q == OP_RELEASE) ? EMPTY : wdata_q;
        end
      end
      S_RESP: begin
        ack_d[gnt_q] = 1'b1;
        ok_d         = res_ok_q;
        rdata_d      = cell_q;
        rr_ptr_d     = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
        if (!res_ok_q) fail_cnt_d = fail_cnt_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= '0;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      cell_q     <= '0;
      res_ok_q   <= 1'b0;
      rr_ptr_q   <= '0;
      ack_q      <= '0;
      ok_q       <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      fail_cnt_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cell_q     <= cell_d;
      res_ok_q   <= res_ok_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      ok_q       <= ok_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      fail_cnt_q <= fail_cnt_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign ack      = ack_q;
  assign ok       = ok_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign fail_cnt = fail_cnt_q;
  assign mem_re   = mem_re_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_grid_cell_arbiter.sv
// Directed bench for grid_cell_arbiter: behavioural grid RAM, latency, arbitration order,
// atomic claim/release and reset abort.
module tb_grid_cell_arbiter;

  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [32*NREQ-1:0]   addr, wdata;
  logic [NREQ-1:0]      ack;
  logic                 ok, busy, mem_re, mem_we;
  logic [31:0]          rdata, fail_cnt, mem_addr, mem_din;
  logic [31:0]          mem_dout = '0;

  int n_checks = 0;
  int n_errors = 0;

  grid_cell_arbiter #(.NREQ(NREQ), .GRID_N(6), .EMPTY(-32'sd1)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ack(ack), .ok(ok), .rdata(rdata), .busy(busy), .fail_cnt(fail_cnt),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Grid RAM model plus activity counters.
  logic [31:0] mem [36];
  int          re_cnt = 0, we_cnt = 0, overlap = 0, multi_ack = 0;
  logic [31:0] last_we_addr = '0, last_we_din = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= mem_addr;
      last_we_din  <= mem_din;
      if (mem_addr < 32'd36) mem[mem_addr] <= mem_din;
    end
    if (mem_re) begin
      re_cnt <= re_cnt + 1;
      if (mem_addr < 32'd36) mem_dout <= mem[mem_addr];
    end
    if (mem_re && mem_we) overlap <= overlap + 1;
    if ($countones(ack) > 1) multi_ack <= multi_ack + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] d);
    op[2*k +: 2]     = o;
    addr[32*k +: 32] = a;
    wdata[32*k +: 32] = d;
    req[k]           = 1'b1;
  endtask

  // Issues one op from an idle arbiter; lat counts edges from acceptance to ack high.
  task automatic do_op(input int k, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_ok, input logic [31:0] exp_rd,
                       input int lat, input string tag);
    int cyc;
    logic got;
    set_req(k, o, a, d);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (ack[k]) got = 1'b1;
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(cyc - 1), 32'(lat));
    check({tag, "_ok"}, 32'(ok), 32'(exp_ok));
    check({tag, "_rdata"}, rdata, exp_rd);
    req[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  // Collects n acks from concurrently raised requests, dropping each req as it is acked.
  task automatic collect(input int n, output int ord [4], output int got_n);
    got_n = 0;
    for (int i = 0; i < 4; i++) ord[i] = -1;
    for (int c = 0; c < 80 && got_n < n; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (ack[k]) begin
          if (got_n < 4) ord[got_n] = k;
          got_n++;
          req[k] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  int we0, re0, got_n, ack_seen;
  int ord [4];

  initial begin
    for (int i = 0; i < 36; i++) mem[i] = 32'hFFFF_FFFF;
    reset = 1'b1;
    req   = '0;
    op    = '0;
    addr  = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fail", fail_cnt, 32'd0);
    check("rst_mem", {28'd0, mem_re, mem_we, 2'd0}, 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_mdin", mem_din, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Claim on an empty cell succeeds and writes once.
    we0 = we_cnt;
    do_op(0, 2'b01, 32'd7, 32'd3, 1'b1, 32'hFFFF_FFFF, 4, "t1");
    check("t1_we_cnt", 32'(we_cnt - we0), 32'd1);
    check("t1_we_addr", last_we_addr, 32'd7);
    check("t1_we_din", last_we_din, 32'd3);

    // Second claim on the same cell fails without writing.
    we0 = we_cnt;
    do_op(1, 2'b01, 32'd7, 32'd5, 1'b0, 32'd3, 3, "t2");
    check("t2_we_cnt", 32'(we_cnt - we0), 32'd0);
    check("t2_fail", fail_cnt, 32'd1);

    // Out-of-range addresses: immediate fail, no memory read.
    re0 = re_cnt;
    do_op(2, 2'b01, 32'd36, 32'd9, 1'b0, 32'hFFFF_FFFF, 1, "t4a");
    do_op(2, 2'b01, 32'hFFFF_FFFF, 32'd9, 1'b0, 32'hFFFF_FFFF, 1, "t4b");
    check("t4_re_cnt", 32'(re_cnt - re0), 32'd0);
    check("t4_fail", fail_cnt, 32'd3);

    // Read by requester 3 brings the round-robin pointer back to 0.
    do_op(3, 2'b00, 32'd7, 32'd0, 1'b1, 32'd3, 3, "rd7");

    // All four claim distinct cells in the same cycle.
    for (int k = 0; k < NREQ; k++) set_req(k, 2'b01, 32'(10 + k), 32'(20 + k));
    collect(4, ord, got_n);
    check("t3_n", 32'(got_n), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_ord%0d", i), 32'(ord[i]), 32'(i));

    // After serving 1, requester 2 is ahead of 0.
    do_op(1, 2'b00, 32'd11, 32'd0, 1'b1, 32'd21, 3, "t3r");
    set_req(0, 2'b00, 32'd10, 32'd0);
    set_req(2, 2'b00, 32'd12, 32'd0);
    collect(2, ord, got_n);
    check("t3b_n", 32'(got_n), 32'd2);
    check("t3b_first", 32'(ord[0]), 32'd2);
    check("t3b_second", 32'(ord[1]), 32'd0);

    // Release only by the owning node id.
    do_op(0, 2'b11, 32'd7, 32'd5, 1'b0, 32'd3, 3, "t5a");
    do_op(0, 2'b11, 32'd7, 32'd3, 1'b1, 32'd3, 4, "t5b");
    do_op(0, 2'b00, 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFF, 3, "t5c");
    check("t5_fail", fail_cnt, 32'd4);

    // Reset during CHK of a claim aborts it.
    we0 = we_cnt;
    set_req(0, 2'b01, 32'd20, 32'd7);
    @(posedge clk);
    @(posedge clk); #1;
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset  = 1'b1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_fail", fail_cnt, 32'd0);
    check("t6_ack", 32'(ack), 32'd0);
    check("t6_mem", {30'd0, mem_re, mem_we}, 32'd0);
    ack_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack != '0) ack_seen++;
    end
    check("t6_no_ack", 32'(ack_seen), 32'd0);
    check("t6_no_we", 32'(we_cnt - we0), 32'd0);
    check("t6_cell", mem[20], 32'hFFFF_FFFF);
    do_op(0, 2'b00, 32'd20, 32'd0, 1'b1, 32'hFFFF_FFFF, 3, "t6r");

    check("overlap", 32'(overlap), 32'd0);
    check("multi_ack", 32'(multi_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
